led_share_arbiter: RTL

Round-robin arbiter that shares the board's five LEDs between three pattern requesters. A free-running N-bit prescaler, the same counter structure as the existing LED counter, produces a slow tick. The tick sets a minimum hold time per grant, so one requester cannot monopolise the display when others are waiting. The block sits between pattern sources (counter, status, debug) and the top-level `led[5:1]` pins.

---
 rtl/led_share_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing five LEDs between three pattern sources,
// with a prescaler tick that sets a minimum hold time per grant under contention.
module led_share_arbiter #(
    parameter int N    = 8,
    parameter int HOLD = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic [3:1] req,
    input  logic [5:1] pat1,
    input  logic [5:1] pat2,
    input  logic [5:1] pat3,
    output logic [3:1] gnt,
    output logic [5:1] led,
    output logic       busy
);

    localparam logic [7:0] HOLD_C = 8'(HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pre_q;
    logic [7:0]   hold_q, hold_d;
    logic [1:0]   last_q, last_d;
    logic [3:1]   gnt_q, gnt_d;
    logic [5:1]   led_q, led_d;
    logic         busy_q, busy_d;

    logic         tick;
    logic [3:1]   others;
    logic [1:0]   nxt_any, nxt_oth;

    // First requester strictly after 'from' in 1->2->3->1 order; 0 when none.
    function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [3:1] r);
        logic [1:0] idx;
        rr_pick = 2'd0;
        idx     = from;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
            if (rr_pick == 2'd0 && r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:1] dec(input logic [1:0] idx);
        dec = 3'b000;
        case (idx)
            2'd1:    dec = 3'b001;
            2'd2:    dec = 3'b010;
            2'd3:    dec = 3'b100;
            default: dec = 3'b000;
        endcase
    endfunction

    function automatic logic [5:1] pat_of(input logic [1:0] idx,
                                          input logic [5:1] p1,
                                          input logic [5:1] p2,
                                          input logic [5:1] p3);
        pat_of = 5'b0;
        case (idx)
            2'd1:    pat_of = p1;
            2'd2:    pat_of = p2;
            2'd3:    pat_of = p3;
            default: pat_of = 5'b0;
        endcase
    endfunction

    assign tick    = &pre_q;
    // In GRANT, last_q is the current grantee.
    assign others  = req & ~dec(last_q);
    assign nxt_any = rr_pick(last_q, req);
    assign nxt_oth = rr_pick(last_q, others);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        led_d   = led_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                gnt_d  = 3'b000;
                led_d  = 5'b0;
                busy_d = 1'b0;
                if (|req) begin
                    state_d = GRANT;
                    last_d  = nxt_any;
                    gnt_d   = dec(nxt_any);
                    led_d   = pat_of(nxt_any, pat1, pat2, pat3);
                    busy_d  = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[last_q] || (hold_q == HOLD_C && |others)) begin
                    hold_d = 8'd0;
                    if (|others) begin
                        // Direct handover: gnt never drops to zero in between.
                        last_d = nxt_oth;
                        gnt_d  = dec(nxt_oth);
                        led_d  = pat_of(nxt_oth, pat1, pat2, pat3);
                        busy_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                        led_d   = 5'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    led_d = pat_of(last_q, pat1, pat2, pat3);
                    if (tick && hold_q != HOLD_C) hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            hold_q  <= 8'd0;
            last_q  <= 2'd3;
            gnt_q   <= 3'b000;
            led_q   <= 5'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_q + 1'b1;
            hold_q  <= hold_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign led  = led_q;
    assign busy = busy_q;

endmodule
